// File: rtl/tile_loader_if.sv
// tile_loader_if: host stream, load control and core write-bus bundle.
// Ports: host_data/valid/ready, load_* control, write bus, status flags.
interface tile_loader_if #(
   parameter int IO_DATA_WIDTH = 16,
   parameter int COLS_WIDTH    = 7
) ();
   logic [IO_DATA_WIDTH-1:0] host_data;
   logic                     host_valid;
   logic                     host_ready;

   logic                     load_start;
   logic                     load_kernels;
   logic [COLS_WIDTH-1:0]    tile_cols;
   logic                     last_tile;
   logic                     fsm_done;

   logic [15:0]              a_input;
   logic [IO_DATA_WIDTH-1:0] b_input;
   logic                     int_mem_we;
   logic                     overlap_cache_we;
   logic                     b_zero;
   logic                     data_ready;
   logic                     busy;

   modport master (
      output host_data, host_valid,
      output load_start, load_kernels, tile_cols, last_tile, fsm_done,
      input  host_ready,
      input  a_input, b_input, int_mem_we, overlap_cache_we, b_zero,
      input  data_ready, busy
   );

   modport slave (
      input  host_data, host_valid,
      input  load_start, load_kernels, tile_cols, last_tile, fsm_done,
      output host_ready,
      output a_input, b_input, int_mem_we, overlap_cache_we, b_zero,
      output data_ready, busy
   );
endinterface

// File: rtl/tile_loader.sv
// tile_loader: streams kernels, one padded input tile and its overlap
// column from the host into the core's write bus, then holds data_ready.
// Ports: clk, arst_n_in (async, active-low), bus (tile_loader_if.slave).
module tile_loader #(
   parameter int IO_DATA_WIDTH = 16,
   parameter int TILE_WIDTH    = 64,
   parameter int TILE_HEIGHT   = 128,
   parameter int TILE_CHANNELS = 2,
   parameter int TILE_OUTCH    = 16,
   parameter int KERNEL_SIZE   = 3
) (
   input logic          clk,
   input logic          arst_n_in,
   tile_loader_if.slave bus
);
   localparam int XW = $clog2(TILE_WIDTH);
   localparam int YW = $clog2(TILE_HEIGHT);
   localparam int CW = $clog2(TILE_CHANNELS);
   localparam int OW = $clog2(TILE_OUTCH);
   localparam int KW = 2;
   localparam int AW = 16;
   localparam int TW = 7;

   typedef enum logic [2:0] {
      IDLE,
      KERNEL,
      INPUT,
      OVERLAP,
      READY
   } state_t;

   state_t state, state_d;

   logic [CW-1:0] inch, inch_d;
   logic [YW-1:0] y, y_d;
   logic [XW-1:0] x, x_d;
   logic [KW-1:0] ky, ky_d;
   logic [KW-1:0] kx, kx_d;
   logic [OW-1:0] oc, oc_d;
   logic [TW-1:0] cols, cols_d;
   logic          last, last_d;

   logic [AW-1:0]            a_q, a_d;
   logic [IO_DATA_WIDTH-1:0] b_q, b_d;
   logic mem_we_q, mem_we_d;
   logic ovl_we_q, ovl_we_d;
   logic zero_q, zero_d;
   logic rdy_q, rdy_d;
   logic busy_q, busy_d;

   logic host_slot;
   logic zero_slot;

   logic last_inch, last_y, last_x;
   logic last_ky, last_kx, last_oc;

   assign last_inch = (inch == CW'(TILE_CHANNELS - 1));
   assign last_y    = (y == YW'(TILE_HEIGHT - 1));
   assign last_x    = (x == XW'(TILE_WIDTH - 1));
   assign last_ky   = (ky == KW'(KERNEL_SIZE - 1));
   assign last_kx   = (kx == KW'(KERNEL_SIZE - 1));
   assign last_oc   = (oc == OW'(TILE_OUTCH - 1));

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         state    <= IDLE;
         inch     <= '0;
         y        <= '0;
         x        <= '0;
         ky       <= '0;
         kx       <= '0;
         oc       <= '0;
         cols     <= '0;
         last     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         mem_we_q <= 1'b0;
         ovl_we_q <= 1'b0;
         zero_q   <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state    <= state_d;
         inch     <= inch_d;
         y        <= y_d;
         x        <= x_d;
         ky       <= ky_d;
         kx       <= kx_d;
         oc       <= oc_d;
         cols     <= cols_d;
         last     <= last_d;
         a_q      <= a_d;
         b_q      <= b_d;
         mem_we_q <= mem_we_d;
         ovl_we_q <= ovl_we_d;
         zero_q   <= zero_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d   = state;
      inch_d    = inch;
      y_d       = y;
      x_d       = x;
      ky_d      = ky;
      kx_d      = kx;
      oc_d      = oc;
      cols_d    = cols;
      last_d    = last;
      a_d       = a_q;
      b_d       = b_q;
      mem_we_d  = 1'b0;
      ovl_we_d  = 1'b0;
      zero_d    = 1'b0;
      rdy_d     = 1'b0;
      host_slot = 1'b0;
      zero_slot = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.load_start) begin
               state_d = bus.load_kernels ? KERNEL : INPUT;
               // Wider requests than the tile are clipped to full width.
               cols_d  = (bus.tile_cols > TW'(TILE_WIDTH)) ?
                         TW'(TILE_WIDTH) : bus.tile_cols;
               last_d  = bus.last_tile;
            end
         end

         KERNEL: begin
            host_slot = 1'b1;
            if (bus.host_valid) begin
               mem_we_d = 1'b1;
               b_d      = bus.host_data;
               a_d      = {1'b1, (AW-1)'({inch, ky, kx, oc})};
               oc_d     = oc + 1'b1;
               if (last_oc) begin
                  oc_d = '0;
                  kx_d = kx + 1'b1;
                  if (last_kx) begin
                     kx_d = '0;
                     ky_d = ky + 1'b1;
                     if (last_ky) begin
                        ky_d   = '0;
                        inch_d = inch + 1'b1;
                        if (last_inch) begin
                           inch_d  = '0;
                           state_d = INPUT;
                        end
                     end
                  end
               end
            end
         end

         INPUT: begin
            // Columns past tile_cols are padding generated locally.
            host_slot = (TW'(x) < cols);
            zero_slot = !host_slot;
            if (zero_slot || bus.host_valid) begin
               mem_we_d = 1'b1;
               zero_d   = zero_slot;
               b_d      = zero_slot ? '0 : bus.host_data;
               a_d      = AW'({inch, y, x});
               x_d      = x + 1'b1;
               if (last_x) begin
                  x_d = '0;
                  y_d = y + 1'b1;
                  if (last_y) begin
                     y_d    = '0;
                     inch_d = inch + 1'b1;
                     if (last_inch) begin
                        inch_d  = '0;
                        state_d = OVERLAP;
                     end
                  end
               end
            end
         end

         OVERLAP: begin
            host_slot = !last;
            zero_slot = last;
            if (zero_slot || bus.host_valid) begin
               ovl_we_d = 1'b1;
               zero_d   = zero_slot;
               b_d      = zero_slot ? '0 : bus.host_data;
               a_d      = AW'({inch, y});
               y_d      = y + 1'b1;
               if (last_y) begin
                  y_d    = '0;
                  inch_d = inch + 1'b1;
                  if (last_inch) begin
                     inch_d  = '0;
                     state_d = READY;
                  end
               end
            end
         end

         READY: begin
            // data_ready trails the final overlap strobe by one cycle.
            rdy_d = !bus.fsm_done;
            if (bus.fsm_done) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign bus.host_ready       = host_slot;
   assign bus.a_input          = a_q;
   assign bus.b_input          = b_q;
   assign bus.int_mem_we       = mem_we_q;
   assign bus.overlap_cache_we = ovl_we_q;
   assign bus.b_zero           = zero_q;
   assign bus.data_ready       = rdy_q;
   assign bus.busy             = busy_q;
endmodule

// File: tb/tb_tile_loader.sv
// tb_tile_loader: directed bench for tile_loader with a queue-based
// write-sequence model and literal spot checks.
module tb_tile_loader;
   logic clk = 1'b0;
   logic arst_n_in;

   always #5 clk = ~clk;

   tile_loader_if bus ();

   tile_loader dut (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .bus       (bus)
   );

   typedef struct packed {
      logic        ovl;
      logic [15:0] addr;
      logic [15:0] data;
      logic        zero;
   } wr_t;

   wr_t exp_q[$];
   wr_t cur;

   int errors = 0;
   int checks = 0;

   int hidx = 0;
   int hcons = 0;
   bit bp_mode = 1'b0;

   int nstrobe = 0;
   int nkern = 0;
   int nzero = 0;
   int novl = 0;
   int ncap = 0;
   logic [15:0] cap [512];
   logic [15:0] last_addr = '0;
   bit rdy_due = 1'b0;

   function automatic void chk(input string name,
                               input logic [63:0] act,
                               input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endfunction

   function automatic logic [15:0] word(input int i);
      int v;
      v = i * 40503 + 4660;
      return v[15:0];
   endfunction

   // Expected write stream for one tile, straight from the address rules.
   task automatic build(input bit kern, input int cols, input bit last);
      int ce;
      int k;
      wr_t e;
      ce = (cols > 64) ? 64 : cols;
      k = hidx;
      exp_q.delete();
      if (kern) begin
         for (int c = 0; c < 2; c++)
            for (int ky = 0; ky < 3; ky++)
               for (int kx = 0; kx < 3; kx++)
                  for (int o = 0; o < 16; o++) begin
                     e.ovl = 1'b0;
                     e.addr = 16'(32768 + c*256 + ky*64 + kx*16 + o);
                     e.data = word(k);
                     e.zero = 1'b0;
                     k++;
                     exp_q.push_back(e);
                  end
      end
      for (int c = 0; c < 2; c++)
         for (int yy = 0; yy < 128; yy++)
            for (int xx = 0; xx < 64; xx++) begin
               e.ovl = 1'b0;
               e.addr = 16'(c*8192 + yy*64 + xx);
               if (xx < ce) begin
                  e.data = word(k);
                  e.zero = 1'b0;
                  k++;
               end else begin
                  e.data = '0;
                  e.zero = 1'b1;
               end
               exp_q.push_back(e);
            end
      for (int c = 0; c < 2; c++)
         for (int yy = 0; yy < 128; yy++) begin
            e.ovl = 1'b1;
            e.addr = 16'(c*128 + yy);
            if (last) begin
               e.data = '0;
               e.zero = 1'b1;
            end else begin
               e.data = word(k);
               e.zero = 1'b0;
               k++;
            end
            exp_q.push_back(e);
         end
   endtask

   // Host driver: presents word(hidx); counts accepted handshakes.
   initial begin
      bus.host_valid = 1'b0;
      bus.host_data = '0;
      forever begin
         @(negedge clk);
         bus.host_valid = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.host_data = word(hidx);
         #1;
         if (bus.host_valid && bus.host_ready) begin
            hidx++;
            hcons++;
         end
      end
   end

   // Compare process: every strobe is matched against the model queue.
   initial begin
      forever begin
         @(negedge clk);
         if (rdy_due) begin
            chk("data_ready_rise", 64'(bus.data_ready), 1);
            rdy_due = 1'b0;
         end
         if (bus.int_mem_we || bus.overlap_cache_we) begin
            chk("we_exclusive",
                64'(bus.int_mem_we & bus.overlap_cache_we), 0);
            nstrobe++;
            if (bus.int_mem_we && bus.a_input[15]) nkern++;
            if (bus.b_zero) nzero++;
            if (bus.overlap_cache_we) novl++;
            if (ncap < 512) cap[ncap] = bus.a_input;
            ncap++;
            last_addr = bus.a_input;
            chk("strobe_expected", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               cur = exp_q.pop_front();
               chk($sformatf("write@%h", cur.addr),
                   64'({bus.overlap_cache_we, bus.a_input,
                        bus.b_input, bus.b_zero}),
                   64'(cur));
               if (exp_q.size() == 0) begin
                  chk("data_ready_early", 64'(bus.data_ready), 0);
                  rdy_due = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic start_load(input bit kern, input int cols, input bit last);
      build(kern, cols, last);
      nstrobe = 0;
      nkern = 0;
      nzero = 0;
      novl = 0;
      ncap = 0;
      hcons = 0;
      @(negedge clk);
      #2;
      bus.load_kernels = kern;
      bus.tile_cols = 7'(cols);
      bus.last_tile = last;
      bus.load_start = 1'b1;
      @(negedge clk);
      #2;
      bus.load_start = 1'b0;
   endtask

   task automatic wait_ready(input int budget);
      int n;
      n = 0;
      while (bus.data_ready !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("load_completes", 64'(bus.data_ready), 1);
      chk("model_drained", 64'(exp_q.size()), 0);
   endtask

   task automatic finish_tile();
      @(negedge clk);
      #2;
      bus.fsm_done = 1'b1;
      @(negedge clk);
      #2;
      bus.fsm_done = 1'b0;
      chk("ready_drop", 64'(bus.data_ready), 0);
      chk("busy_drop", 64'(bus.busy), 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_a"}, 64'(bus.a_input), 0);
      chk({tag, "_b"}, 64'(bus.b_input), 0);
      chk({tag, "_mem_we"}, 64'(bus.int_mem_we), 0);
      chk({tag, "_ovl_we"}, 64'(bus.overlap_cache_we), 0);
      chk({tag, "_b_zero"}, 64'(bus.b_zero), 0);
      chk({tag, "_ready"}, 64'(bus.data_ready), 0);
      chk({tag, "_busy"}, 64'(bus.busy), 0);
      chk({tag, "_host_ready"}, 64'(bus.host_ready), 0);
   endtask

   initial begin
      int n;
      int s0;
      arst_n_in = 1'b0;
      bus.load_start = 1'b0;
      bus.load_kernels = 1'b0;
      bus.tile_cols = '0;
      bus.last_tile = 1'b0;
      bus.fsm_done = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      #2;
      arst_n_in = 1'b1;

      // Kernel phase then full-width tile, continuous host stream.
      start_load(1'b1, 64, 1'b0);
      @(negedge clk);
      #1;
      chk("first_write", 64'({bus.int_mem_we, bus.a_input}), 64'h1_8000);
      wait_ready(40000);
      chk("k_addr0", 64'(cap[0]), 64'h8000);
      chk("k_addr16", 64'(cap[16]), 64'h8010);
      chk("k_addr48", 64'(cap[48]), 64'h8040);
      chk("k_addr144", 64'(cap[144]), 64'h8100);
      chk("k_addr287", 64'(cap[287]), 64'h81AF);
      chk("in_addr0", 64'(cap[288]), 64'h0000);
      chk("kernel_strobes", 64'(nkern), 288);
      chk("k_host_words", 64'(hcons), 16928);
      chk("k_ovl_writes", 64'(novl), 256);

      // load_start while READY is ignored.
      s0 = nstrobe;
      @(negedge clk);
      #2;
      bus.load_start = 1'b1;
      @(negedge clk);
      #2;
      bus.load_start = 1'b0;
      repeat (3) @(negedge clk);
      chk("ready_hold", 64'(bus.data_ready), 1);
      chk("busy_hold", 64'(bus.busy), 1);
      chk("no_restart", 64'(nstrobe), 64'(s0));
      finish_tile();

      // Padding: 10 host columns, 54 zero columns per row.
      start_load(1'b0, 10, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!(bus.int_mem_we && bus.a_input == 16'h000A) && n < 200);
      chk("pad_first_zero", 64'({bus.b_zero, bus.b_input}), 64'h1_0000);
      chk("pad_host_ready", 64'(bus.host_ready), 0);
      bus.fsm_done = 1'b1;
      @(negedge clk);
      #2;
      bus.fsm_done = 1'b0;
      chk("done_ignored", 64'(bus.busy), 1);
      wait_ready(40000);
      chk("pad_host_words", 64'(hcons), 2816);
      chk("pad_zero_writes", 64'(nzero), 13824);
      chk("pad_addr9", 64'(cap[9]), 64'h0009);
      chk("pad_addr64", 64'(cap[64]), 64'h0040);
      finish_tile();

      // Last tile with tile_cols = 0: everything zero-filled.
      start_load(1'b0, 0, 1'b1);
      wait_ready(40000);
      chk("last_host_words", 64'(hcons), 0);
      chk("last_zero_writes", 64'(nzero), 16640);
      chk("last_ovl_writes", 64'(novl), 256);
      chk("last_ovl_addr", 64'(last_addr), 64'h00FF);
      finish_tile();

      // Backpressure plus clipped tile_cols.
      bp_mode = 1'b1;
      start_load(1'b1, 70, 1'b0);
      wait_ready(60000);
      chk("bp_host_words", 64'(hcons), 16928);
      chk("bp_strobes", 64'(nstrobe), 16928);
      finish_tile();
      bp_mode = 1'b0;

      // Reset in the middle of row y = 5.
      start_load(1'b0, 64, 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!(bus.int_mem_we && bus.a_input == 16'h0140) && n < 1000);
      chk("reached_y5", 64'(bus.a_input), 64'h0140);
      arst_n_in = 1'b0;
      exp_q.delete();
      rdy_due = 1'b0;
      #1;
      check_zero_outputs("midreset");
      repeat (2) @(negedge clk);
      #2;
      arst_n_in = 1'b1;
      s0 = nstrobe;
      repeat (20) @(negedge clk);
      chk("quiet_after_reset", 64'(nstrobe), 64'(s0));
      chk("idle_after_reset", 64'(bus.busy), 0);

      start_load(1'b0, 64, 1'b0);
      repeat (6) @(negedge clk);
      #1;
      chk("reload_addr0", 64'(cap[0]), 64'h0000);
      chk("reload_addr5", 64'(cap[5]), 64'h0005);
      arst_n_in = 1'b0;
      exp_q.delete();
      rdy_due = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      arst_n_in = 1'b1;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tile_loader.md
# tile_loader

Upstream feeder of the convolution chip core: streams kernel words, one input-feature-map tile and the tile's right-hand overlap column from a host valid/ready stream. It drives the core's shared write bus (`a_input` address, `b_input` data, `int_mem_we`, `overlap_cache_we`, `b_zero`) and raises `data_ready` when the tile is resident. It holds `data_ready` until the core reports `fsm_done`, then accepts the next tile. It generates zero-padding writes itself, without consuming host words.

## Interface
- IO_DATA_WIDTH, 16, host word / write-bus width
- TILE_WIDTH, 64, tile columns (x: 6 bits)
- TILE_HEIGHT, 128, tile rows (y: 7 bits)
- TILE_CHANNELS, 2, input channels per tile (inch: 1 bit)
- TILE_OUTCH, 16, output channels held in kernel memory (4 bits)
- KERNEL_SIZE, 3, kernel taps per dimension (ky/kx address fields are 2 bits)
- clk  in  1  clock; single clock domain
- arst_n_in  in  1  reset, asynchronous, active-low
- host_data  in  16  data word from host
- host_valid  in  1  host word present
- host_ready  out  1  loader accepts host_data this cycle
- load_start  in  1  one-cycle pulse: begin loading a tile
- load_kernels  in  1  sampled with load_start; 1 = run kernel phase first
- tile_cols  in  7  valid columns in this tile, 0..64
- last_tile  in  1  sampled with load_start; 1 = overlap column is zero-filled
- fsm_done  in  1  core finished consuming the current tile
- a_input  out  16  write address; bit15 = 1 selects kernel memory
- b_input  out  16  write data
- int_mem_we  out  1  input/kernel memory write strobe
- overlap_cache_we  out  1  overlap cache write strobe
- b_zero  out  1  zero-fill write; b_input is also driven 0
- data_ready  out  1  tile resident; core may compute
- busy  out  1  state != IDLE

## Operation
- States: IDLE, KERNEL, INPUT, OVERLAP, READY.
- IDLE + load_start: go to KERNEL if load_kernels = 1, otherwise INPUT. Sample tile_cols and last_tile at this point.
- load_start outside IDLE is ignored.
- KERNEL: 288 host words.
  - Counter order inch, ky, kx, outch; outch is fastest. ky and kx run 0..2.
  - Address = {1, 6'b0, inch, ky[1:0], kx[1:0], outch[3:0]}.
  - Entries with ky = 3 or kx = 3 are never written.
  - After the last word, go to INPUT.
- INPUT: 2×128×64 = 16384 write cycles.
  - Counter order inch, y, x; x is fastest.
  - Address = {2'b00, inch, y[6:0], x[5:0]}.
  - x < tile_cols: consume one host word.
  - x ≥ tile_cols: zero write, host_ready = 0.
  - Then go to OVERLAP.
- OVERLAP: 256 writes, order inch, y; address = {8'b0, inch, y[6:0]}.
  - Asserts overlap_cache_we, not int_mem_we.
  - last_tile = 1: all 256 writes are zero-fill, no host words consumed.
  - Then go to READY.
- READY: data_ready = 1, no writes. On fsm_done go to IDLE, which also clears data_ready.
- Zero-fill write: int_mem_we or overlap_cache_we = 1, b_zero = 1, b_input = 0.
- Host write: b_zero = 0, b_input = accepted host_data.
- host_ready = 1 only in a host-consuming slot. When host_valid = 0 in that slot: counters hold and no strobe is issued.
- tile_cols = 0: the entire input phase is zero-fill.
- tile_cols > 64: treated as 64.

## Timing
- All outputs are registered.
- Reset values: every output is 0, state = IDLE, counters = 0.
- A write strobe is high for exactly one cycle per write. Its address and data are valid in the same cycle.
- Write latency: strobe appears the cycle after host_valid & host_ready; zero-fill writes issue one per cycle.
- Throughput: one write per cycle at most. At most one strobe per cycle; int_mem_we and overlap_cache_we are mutually exclusive.
- host_ready may be combinational from state/counters but must not depend on host_valid.
- IDLE→first write: 2 cycles after the load_start pulse (state change, then registered strobe).
- data_ready rises in the cycle after the final overlap write. It falls in the cycle after fsm_done is sampled high.
- fsm_done outside READY is ignored.
- Reset mid-load: all outputs go to 0 asynchronously and the state returns to IDLE. The partial tile is discarded; no write strobe fires after reset deasserts until a new load_start.
- Counters wrap only via a state transition; there is no free-running wrap.

## Test plan
- Kernel load: load_kernels = 1, tile_cols = 64, last_tile = 0, stream with host_valid always 1.
  - Word #0 → a_input = 0x8000.
  - Word #16 → a_input = 0x8010 (kx = 1).
  - Word #48 → a_input = 0x8040 (ky = 1).
  - Word #144 → a_input = 0x8100 (inch = 1).
  - Exactly 288 kernel strobes.
- Padding: tile_cols = 10, load_kernels = 0.
  - Each row gives 10 host writes, then 54 zero writes with b_zero = 1, b_input = 0, host_ready = 0.
  - Total host words = 2×128×10 + 256 = 2816.
- Last tile: last_tile = 1. All 256 overlap_cache_we writes are zero-fill. data_ready = 1 one cycle after overlap address 0xFF.
- Backpressure: toggle host_valid randomly. The write sequence and addresses must be identical to the continuous run, and no strobe fires without an accepted word.
- Handshake: in READY, pulse load_start → ignored. Pulse fsm_done → data_ready = 0 next cycle, busy = 0.
- Reset: assert arst_n_in at INPUT y = 5 → all outputs 0 immediately. After release, no strobes until load_start; the reload starts at address 0x0000.
